// File: rtl/booth_mul_sched.sv
// booth_mul_sched: round-robin scheduler that shares one multi-cycle booth multiplier core
// among NREQ requesters. Optional BUSY watchdog enabled by defining BOOTH_SCHED_TIMEOUT_EN.
module booth_mul_sched #(
    parameter int W      = 521,
    parameter int NREQ   = 4,
    parameter int IDW    = 2,
    parameter int TO_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                mul_start,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic                mul_done,
    input  logic [2*W-1:0]      mul_c,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_c,
    output logic                rsp_err,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    // Handshakes: a request moves when req_valid[i] & req_ready[i]; a response moves when
    // rsp_valid & rsp_ready, and rsp_id/rsp_c/rsp_err hold while rsp_valid & !rsp_ready.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    generate
        if (NREQ < 2 || IDW != $clog2(NREQ) || TO_CYC < 1) begin : g_bad_params
            $error("booth_mul_sched: need NREQ>=2, IDW==clog2(NREQ), TO_CYC>=1");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [W-1:0]     r_mul_a;
    logic [W-1:0]     r_mul_b;
    logic [IDW-1:0]   r_rsp_id;
    logic [2*W-1:0]   r_rsp_c;

    logic             w_gnt_any;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_cand;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;
    logic             w_timeout;

    // Scan offsets from NREQ down to 1 so the last hit is the first valid index after r_rr_ptr.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_cand = IDW'(w_sum - (IDW+1)'(NREQ));
            end else begin
                w_cand = IDW'(w_sum);
            end
            if (req_valid[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == IDW'(i)) begin
                w_sel_a = req_a[i*W +: W];
                w_sel_b = req_b[i*W +: W];
                req_ready[i] = (r_state == S_IDLE) && !rst && w_gnt_any;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= IDW'(NREQ-1);
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_rsp_id <= '0;
            r_rsp_c  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_mul_a  <= w_sel_a;
                        r_mul_b  <= w_sel_b;
                        r_rsp_id <= w_gnt_id;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_BUSY;
                S_BUSY: begin
                    // mul_done is only meaningful here; pulses in other states are dropped.
                    if (mul_done) begin
                        r_rsp_c <= mul_c;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_c <= '0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rr_ptr <= r_rsp_id;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BOOTH_SCHED_TIMEOUT_EN
    localparam int TOW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [TOW-1:0] r_to_cnt;
    logic           r_rsp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_to_cnt <= '0;
            end else if (r_state == S_BUSY) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (r_state == S_BUSY) begin
                if (mul_done) begin
                    r_rsp_err <= 1'b0;
                end else if (w_timeout) begin
                    r_rsp_err <= 1'b1;
                end
            end
        end
    end

    assign w_timeout = (r_state == S_BUSY) && (r_to_cnt == TOW'(TO_CYC-1));
    assign rsp_err   = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign mul_start = (r_state == S_ISSUE);
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_c     = r_rsp_c;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_booth_mul_sched.sv
// tb_booth_mul_sched: directed vector table plus hand sequences for booth_mul_sched;
// the bench plays the multiplier core and the response consumer.
module tb_booth_mul_sched;

    localparam int W      = 521;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int TO_CYC = 16;
    localparam int CW     = 2*W;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_done;
    logic [CW-1:0]     mul_c;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [CW-1:0]     rsp_c;
    logic              rsp_err;
    logic              busy;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] exp_q[$];

    typedef struct {
        logic [NREQ-1:0] valid;
        int              gid;
        logic [W-1:0]    a;
        logic [W-1:0]    b;
        logic [CW-1:0]   exp_c;
        int              lat;
        int              hold;
        bit              glitch;
    } vec_t;

    vec_t vecs[10];

    booth_mul_sched #(.W(W), .NREQ(NREQ), .IDW(IDW), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_c(mul_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c),
        .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (low 200 bits)", name, act[199:0], exp[199:0]);
        end
    endtask

    function automatic vec_t mk(input logic [NREQ-1:0] v, input int g, input longint a,
                                input longint b, input longint c, input int lat,
                                input int hold, input bit glitch);
        vec_t r;
        r.valid  = v;
        r.gid    = g;
        r.a      = {{(W-64){a[63]}}, a};
        r.b      = {{(W-64){b[63]}}, b};
        r.exp_c  = {{(CW-64){c[63]}}, c};
        r.lat    = lat;
        r.hold   = hold;
        r.glitch = glitch;
        return r;
    endfunction

    task automatic drive_req(input logic [NREQ-1:0] v, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = a;
            req_b[i*W +: W] = b;
        end
    endtask

    // One full transaction: grant, start pulse, core latency lat (done at start+lat), response.
    task automatic do_txn(input vec_t v);
        logic [CW-1:0]   held;
        logic [NREQ-1:0] exp_rdy;
        bit              bad;
        exp_rdy = '0;
        exp_rdy[v.gid] = 1'b1;
        drive_req(v.valid, v.a, v.b);
        #1;
        chk("grant_ready", CW'(req_ready), CW'(exp_rdy));
        exp_q.push_back(v.exp_c);
        step();
        chk("start_pulse", CW'(mul_start), CW'(1));
        chk("mul_a", CW'(mul_a), CW'(v.a));
        chk("mul_b", CW'(mul_b), CW'(v.b));
        chk("ready_low_issue", CW'(req_ready), CW'(0));
        chk("busy_issue", CW'(busy), CW'(1));
        if (v.glitch) begin
            mul_done = 1'b1;
            mul_c    = '1;
        end
        step();
        mul_done = 1'b0;
        mul_c    = '0;
        chk("start_one_cycle", CW'(mul_start), CW'(0));
        bad = 1'b0;
        repeat (v.lat - 1) begin
            if (rsp_valid || mul_a !== v.a || mul_b !== v.b || req_ready != '0) bad = 1'b1;
            step();
        end
        if (rsp_valid || mul_a !== v.a || mul_b !== v.b) bad = 1'b1;
        chk("busy_wait_stable", CW'(bad), CW'(0));
        mul_done = 1'b1;
        mul_c    = v.exp_c;
        step();
        mul_done = 1'b0;
        mul_c    = '0;
        chk("rsp_valid", CW'(rsp_valid), CW'(1));
        chk("rsp_id", CW'(rsp_id), CW'(v.gid));
        chk("rsp_err", CW'(rsp_err), CW'(0));
        chk("rsp_c", rsp_c, exp_q.pop_front());
        held = rsp_c;
        bad  = 1'b0;
        repeat (v.hold) begin
            step();
            if (!rsp_valid || rsp_c !== held || req_ready != '0 || rsp_id != IDW'(v.gid)) bad = 1'b1;
        end
        if (v.hold > 0) chk("backpressure_hold", CW'(bad), CW'(0));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_drop", CW'(rsp_valid), CW'(0));
        chk("idle_bubble", CW'(busy), CW'(0));
    endtask

    initial begin
        vec_t          v;
        logic [W-1:0]  wmin;
        logic [CW-1:0] cmax;
        int            cyc;
        bit            seen;

        rst       = 1'b1;
        rsp_ready = 1'b0;
        mul_done  = 1'b0;
        mul_c     = '0;
        drive_req('0, '0, '0);

        vecs[0] = mk(4'b1111, 0, -1, -1, 1, 3, 0, 1'b1);
        vecs[1] = mk(4'b1111, 1, 3, -2, -6, 5, 0, 1'b1);
        vecs[2] = mk(4'b1111, 2, 7, 6, 42, 1, 0, 1'b0);
        vecs[3] = mk(4'b1111, 3, -5, -4, 20, 4, 0, 1'b0);
        vecs[4] = mk(4'b1111, 0, 0, 123, 0, 2, 0, 1'b0);
        vecs[5] = mk(4'b0001, 0, 3, 5, 15, 522, 0, 1'b0);
        vecs[6] = mk(4'b0100, 2, 12345, -1, -12345, 2, 0, 1'b0);
        vecs[7] = mk(4'b1010, 3, 100, 100, 10000, 2, 10, 1'b0);
        vecs[8] = mk(4'b1010, 1, -1, 1, -1, 1, 0, 1'b0);
        vecs[9] = mk(4'b0011, 0, 2, -3, -6, 3, 0, 1'b0);

        repeat (3) step();
        chk("reset_busy", CW'(busy), CW'(0));
        chk("reset_state", CW'(dbg_state), CW'(0));
        chk("reset_rsp_valid", CW'(rsp_valid), CW'(0));
        chk("reset_mul_start", CW'(mul_start), CW'(0));
        chk("reset_rsp_c", rsp_c, CW'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            do_txn(vecs[i]);
        end
        drive_req('0, '0, '0);
        step();

        // Most negative operand squared: only bit 2W-2 of the product is set.
        wmin = '0;
        wmin[W-1] = 1'b1;
        cmax = '0;
        cmax[CW-2] = 1'b1;
        v = mk(4'b0001, 0, 0, 0, 0, 2, 0, 1'b0);
        v.a = wmin;
        v.b = wmin;
        v.exp_c = cmax;
        do_txn(v);

        // Reset while BUSY, then a stray mul_done must not produce a response.
        drive_req(4'b0010, W'(9), W'(9));
        #1;
        chk("mid_grant", CW'(req_ready), CW'(4'b0010));
        step();
        drive_req('0, '0, '0);
        repeat (3) step();
        chk("mid_busy", CW'(busy), CW'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_req_ready", CW'(req_ready), CW'(0));
        chk("rst_mul_start", CW'(mul_start), CW'(0));
        chk("rst_mul_a", CW'(mul_a), CW'(0));
        chk("rst_mul_b", CW'(mul_b), CW'(0));
        chk("rst_rsp_valid", CW'(rsp_valid), CW'(0));
        chk("rst_rsp_id", CW'(rsp_id), CW'(0));
        chk("rst_rsp_c", rsp_c, CW'(0));
        chk("rst_rsp_err", CW'(rsp_err), CW'(0));
        chk("rst_busy", CW'(busy), CW'(0));
        mul_done = 1'b1;
        mul_c    = '1;
        step();
        mul_done = 1'b0;
        mul_c    = '0;
        chk("late_done_busy", CW'(busy), CW'(0));
        step();
        chk("late_done_rsp", CW'(rsp_valid), CW'(0));
        chk("late_done_rsp_c", rsp_c, CW'(0));

        // Pointer is back at NREQ-1, so requester 0 wins again.
        do_txn(mk(4'b1111, 0, -7, 3, -21, 2, 0, 1'b0));
        drive_req('0, '0, '0);
        step();

`ifdef BOOTH_SCHED_TIMEOUT_EN
        drive_req(4'b0001, W'(4), W'(4));
        #1;
        chk("to_grant", CW'(req_ready), CW'(4'b0001));
        step();
        drive_req('0, '0, '0);
        cyc  = 1;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            step();
            cyc++;
            if (rsp_valid) seen = 1'b1;
        end
        chk("to_seen", CW'(seen), CW'(1));
        chk("to_cycle", CW'(cyc), CW'(2 + TO_CYC));
        chk("to_err", CW'(rsp_err), CW'(1));
        chk("to_rsp_c", rsp_c, CW'(0));
        mul_done = 1'b1;
        mul_c    = CW'(16);
        step();
        mul_done = 1'b0;
        mul_c    = '0;
        chk("to_late_done", rsp_c, CW'(0));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("to_idle", CW'(busy), CW'(0));
`else
        cyc  = 0;
        seen = 1'b0;
        drive_req(4'b0001, W'(4), W'(4));
        step();
        drive_req('0, '0, '0);
        for (int n = 0; n < 40; n++) begin
            step();
            cyc++;
            if (rsp_valid) seen = 1'b1;
        end
        chk("no_timeout_wait", CW'(seen), CW'(0));
        chk("no_timeout_busy", CW'(busy), CW'(1));
        chk("no_timeout_err", CW'(rsp_err), CW'(0));
        mul_done = 1'b1;
        mul_c    = CW'(16);
        step();
        mul_done = 1'b0;
        mul_c    = '0;
        chk("no_timeout_rsp_c", rsp_c, CW'(16));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("no_timeout_idle", CW'(busy + cyc - 40), CW'(0));
`endif

        chk("scoreboard_empty", CW'(exp_q.size()), CW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
